crc_serial_gen: RTL and testbench
=================================

# crc_serial_gen

Parametrised serial CRC generator for bit-serial links. It accepts a message one bit per clock and computes any CRC of width CRC_W with polynomial POLY and preset INIT. After the last message bit it emits the CRC MSB-first on a valid/ready output stream. It sits between a bit-serial framer and the line serialiser, and generalises the fixed 4-bit G(D)=D^4+D^3+1 generator to arbitrary width, polynomial and preset, adding explicit framing, backpressure and abort.

## Interface
- CRC_W, 4: CRC width, 2..32.
- POLY, 4'b1001: generator polynomial without the implicit x^CRC_W term; the default is D^4+D^3+1.
- INIT, 0: register preset loaded on crc_start.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- crc_start  input  1  one-cycle pulse that presets the register and opens a frame.
- data  input  1  message bit, MSB of the message first.
- data_valid  input  1  data qualifier.
- data_last  input  1  marks the final message bit; sampled only with data_valid.
- data_ready  output  1  block accepts a message bit this cycle.
- crc_out  output  1  serial output bit, registered.
- crc_valid  output  1  crc_out is valid.
- crc_ready  input  1  downstream accepts crc_out.
- crc_last  output  1  high with the final CRC bit.
- busy  output  1  frame in progress (state != IDLE).

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- IDLE -> COLLECT on crc_start; crc <= INIT.
- COLLECT: data_ready=1. On data_valid & data_ready: fb = data ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
- COLLECT -> EMIT when data_valid & data_ready & data_last. The last bit is folded in first, and a bit index is loaded with CRC_W-1.
- EMIT: crc_valid=1, crc_out=crc[idx]. Each crc_valid & crc_ready decrements idx. crc_last = (idx==0). A transfer with idx==0 goes to IDLE.
- crc_ready low holds crc_out, crc_valid, crc_last and idx unchanged.
- crc_start in any state aborts the current frame: crc <= INIT, state <= COLLECT, crc_valid drops the next cycle. crc_start has priority over a simultaneous data bit or output transfer, and that data bit is dropped.
- data_valid in IDLE or EMIT is ignored (data_ready=0). data_last without data_valid is ignored.
- An empty message (no bits) is not supported. A frame must contain at least one data_valid with data_last.
- Width rules: POLY and INIT are truncated to CRC_W bits. idx is $clog2(CRC_W) bits wide and never wraps below 0.

## Timing
- Reset values: data_ready=0, crc_out=0, crc_valid=0, crc_last=0, busy=0, crc=INIT, state=IDLE.
- crc_start at edge N gives data_ready=1 and busy=1 after edge N.
- Last bit accepted at edge N gives the CRC MSB on crc_out with crc_valid=1 after edge N.
- With crc_ready held high, the CRC occupies exactly CRC_W consecutive cycles and crc_last is on the CRC_W-th cycle. busy falls after the final transfer edge.
- Back-to-back frames: crc_start is legal in the same cycle as the final CRC transfer. That transfer completes and the new frame opens.

## Configuration
- CRC_PASSTHRU_EN defined:
  - The output stream carries the full codeword. Each accepted message bit appears on crc_out with crc_valid=1 one cycle after acceptance, followed directly by the CRC_W CRC bits.
  - In COLLECT, data_ready = !crc_valid | crc_ready, so the message is backpressured through the output.
  - crc_last marks only the final CRC bit.
- CRC_PASSTHRU_EN undefined:
  - Only CRC bits are emitted, as described above.
  - data_ready ignores crc_ready.

## Test plan
- Defaults, crc_start, then bits 1,0,1,1 with last on the 4th bit, crc_ready=1 -> crc_out 0,1,0,1 on 4 consecutive crc_valid cycles; crc_last on the 4th; busy low after.
- Same frame with crc_ready low for 3 cycles after the first CRC bit -> crc_out holds 0 and crc_valid stays high; sequence resumes 1,0,1; exactly 4 transfers total.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, message ASCII "123456789" (72 bits, MSB first) -> CRC 16'h29B1 serialised MSB-first.
- crc_start asserted mid-EMIT after 2 CRC bits, then bits 1,0,1,1 -> no further CRC bits of the old frame are emitted; the new frame yields 0,1,0,1.
- Reset asserted mid-COLLECT -> all outputs 0 immediately; after release, data_valid is ignored until crc_start.
- CRC_PASSTHRU_EN, bits 1,0,1,1 -> crc_out 1,0,1,1,0,1,0,1 over 8 valid cycles; crc_last only on the 8th.

Source files
------------

// File: rtl/crc_serial_gen.sv
// Bit-serial CRC generator: folds one message bit per clock, then streams the CRC MSB-first.
// Optional CRC_PASSTHRU_EN: message bits are forwarded on crc_out ahead of the CRC.
module crc_serial_gen #(
  parameter int          CRC_W = 4,
  parameter logic [31:0] POLY  = 32'h0000_0009,
  parameter logic [31:0] INIT  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic crc_start,
  input  logic data,
  input  logic data_valid,
  input  logic data_last,
  output logic data_ready,
  output logic crc_out,
  output logic crc_valid,
  input  logic crc_ready,
  output logic crc_last,
  output logic busy
);

  localparam int                 IDX_W   = $clog2(CRC_W);
  localparam logic [CRC_W-1:0]   POLY_T  = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0]   INIT_T  = INIT[CRC_W-1:0];
  localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(CRC_W - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_T : {CRC_W{1'b0}});
  endfunction

  state_t           state_r, state_nx_s;
  logic [CRC_W-1:0] crc_r, crc_nx_s, step_s;
  logic [IDX_W-1:0] idx_r, idx_nx_s, idx_dec_s;
  logic             crc_out_r, out_nx_s;
  logic             crc_valid_r, valid_nx_s;
  logic             crc_last_r, last_nx_s;
  logic             data_ready_s, accept_s, xfer_s;
`ifdef CRC_PASSTHRU_EN
  // tail_r: crc_out still holds the final message bit; the CRC starts after its transfer
  logic             tail_r, tail_nx_s;
`endif

`ifdef CRC_PASSTHRU_EN
  assign data_ready_s = (state_r == ST_COLLECT) && (!crc_valid_r || crc_ready);
`else
  assign data_ready_s = (state_r == ST_COLLECT);
`endif
  assign accept_s  = data_valid && data_ready_s;
  assign xfer_s    = crc_valid_r && crc_ready;
  assign step_s    = crc_step(crc_r, data);
  assign idx_dec_s = idx_r - IDX_ONE;

  // Next-state and next-output logic; crc_start overrides everything else
  always_comb begin
    state_nx_s = state_r;
    crc_nx_s   = crc_r;
    idx_nx_s   = idx_r;
    out_nx_s   = crc_out_r;
    valid_nx_s = crc_valid_r;
    last_nx_s  = crc_last_r;
`ifdef CRC_PASSTHRU_EN
    tail_nx_s  = tail_r;
`endif
    if (crc_start) begin
      state_nx_s = ST_COLLECT;
      crc_nx_s   = INIT_T;
      idx_nx_s   = IDX_ZERO;
      out_nx_s   = 1'b0;
      valid_nx_s = 1'b0;
      last_nx_s  = 1'b0;
`ifdef CRC_PASSTHRU_EN
      tail_nx_s  = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_COLLECT: begin
`ifdef CRC_PASSTHRU_EN
          if (xfer_s) begin
            valid_nx_s = 1'b0;
            out_nx_s   = 1'b0;
          end else begin
            valid_nx_s = crc_valid_r;
          end
          if (accept_s) begin
            crc_nx_s   = step_s;
            out_nx_s   = data;
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b0;
            if (data_last) begin
              state_nx_s = ST_EMIT;
              idx_nx_s   = IDX_TOP;
              tail_nx_s  = 1'b1;
            end else begin
              state_nx_s = ST_COLLECT;
            end
          end else begin
            crc_nx_s = crc_r;
          end
`else
          if (accept_s && data_last) begin
            crc_nx_s   = step_s;
            state_nx_s = ST_EMIT;
            idx_nx_s   = IDX_TOP;
            out_nx_s   = step_s[CRC_W-1];
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b0;
          end else if (accept_s) begin
            crc_nx_s = step_s;
          end else begin
            crc_nx_s = crc_r;
          end
`endif
        end
        ST_EMIT: begin
          if (!xfer_s) begin
            state_nx_s = ST_EMIT;
`ifdef CRC_PASSTHRU_EN
          end else if (tail_r) begin
            tail_nx_s = 1'b0;
            out_nx_s  = crc_r[IDX_TOP];
            last_nx_s = 1'b0;
`endif
          end else if (idx_r == IDX_ZERO) begin
            state_nx_s = ST_IDLE;
            out_nx_s   = 1'b0;
            valid_nx_s = 1'b0;
            last_nx_s  = 1'b0;
          end else begin
            idx_nx_s  = idx_dec_s;
            out_nx_s  = crc_r[idx_dec_s];
            last_nx_s = (idx_dec_s == IDX_ZERO);
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          out_nx_s   = 1'b0;
          valid_nx_s = 1'b0;
          last_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // State, CRC register, bit index and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      crc_r       <= INIT_T;
      idx_r       <= IDX_ZERO;
      crc_out_r   <= 1'b0;
      crc_valid_r <= 1'b0;
      crc_last_r  <= 1'b0;
`ifdef CRC_PASSTHRU_EN
      tail_r      <= 1'b0;
`endif
    end else begin
      state_r     <= state_nx_s;
      crc_r       <= crc_nx_s;
      idx_r       <= idx_nx_s;
      crc_out_r   <= out_nx_s;
      crc_valid_r <= valid_nx_s;
      crc_last_r  <= last_nx_s;
`ifdef CRC_PASSTHRU_EN
      tail_r      <= tail_nx_s;
`endif
    end
  end

  assign data_ready = data_ready_s;
  assign crc_out    = crc_out_r;
  assign crc_valid  = crc_valid_r;
  assign crc_last   = crc_last_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_crc_serial_gen.sv
// Self-checking bench for crc_serial_gen: a 4-bit default instance and a CRC-16/CCITT instance share stimulus.
module tb_crc_serial_gen;

`ifdef CRC_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic crc_start = 1'b0, data = 1'b0, data_valid = 1'b0, data_last = 1'b0, crc_ready = 1'b0;
  logic dr_a, out_a, val_a, last_a, busy_a;
  logic dr_b, out_b, val_b, last_b, busy_b;

  int checks = 0, failures = 0, cyc = 0, stall_left = 0;
  bit stall_on = 1'b0;
  bit qa[$], la[$], qb[$], lb[$];
  int ca[$];

  typedef struct {
    logic [71:0] msg;
    int          len;
    logic [3:0]  ra;
    bit          ra_k;
    logic [15:0] rb;
    bit          rb_k;
  } vec_t;
  vec_t tab[6];

  crc_serial_gen #(.CRC_W(4), .POLY(32'h0000_0009), .INIT(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .crc_start(crc_start), .data(data), .data_valid(data_valid),
    .data_last(data_last), .data_ready(dr_a), .crc_out(out_a), .crc_valid(val_a),
    .crc_ready(crc_ready), .crc_last(last_a), .busy(busy_a));

  crc_serial_gen #(.CRC_W(16), .POLY(32'h0000_1021), .INIT(32'h0000_FFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .crc_start(crc_start), .data(data), .data_valid(data_valid),
    .data_last(data_last), .data_ready(dr_b), .crc_out(out_b), .crc_valid(val_b),
    .crc_ready(crc_ready), .crc_last(last_b), .busy(busy_b));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer (valid & ready) mid-cycle, with its cycle number
  always @(negedge clk) begin
    if (val_a && crc_ready) begin
      qa.push_back(out_a); la.push_back(last_a); ca.push_back(cyc);
    end
    if (val_b && crc_ready) begin
      qb.push_back(out_b); lb.push_back(last_b);
    end
  end

  // Reference: mod-2 long division of (message * x^W) with the preset folded into the leading W bits
  function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bit msg[$]);
    bit a[$];
    logic [31:0] r;
    r = 32'd0;
    a = msg;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = a[i] ^ init[w-1-i];
    for (int i = 0; i < msg.size(); i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
      end
    end
    for (int i = 0; i < w; i++) r[w-1-i] = a[msg.size()+i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_stream(input string nm, input bit got[$], input bit gl[$], input int base,
                            input bit exp[$]);
    int n;
    n = got.size() - base;
    check({nm, "_len"}, n, exp.size());
    for (int i = 0; i < n && i < exp.size(); i++) begin
      check($sformatf("%s_bit%0d", nm, i), got[base+i], exp[i]);
      check($sformatf("%s_last%0d", nm, i), gl[base+i], (i == exp.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  // Drive crc_ready for the coming cycle: a forced 3-cycle stall at stream index stall_at, else random
  task automatic set_ready(input int stall_pct, input int stall_at, input int base_a, input bit ea[$]);
    int na;
    na = qa.size() - base_a;
    if (stall_left > 0 && (stall_on || (val_a && na == stall_at))) begin
      stall_on = 1'b1;
      check("stall_valid", val_a, 32'd1);
      check("stall_out", out_a, ea[stall_at]);
      crc_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      crc_ready = ($urandom_range(99) >= stall_pct);
    end
  endtask

  task automatic run_frame(input logic [71:0] msg, input int len, input logic [3:0] ra_tab,
                           input bit ra_k, input logic [15:0] rb_tab, input bit rb_k,
                           input int gap_pct, input int stall_pct, input int stall_at,
                           input int abort_after, input bit chain, input bit no_start,
                           input bit timing);
    bit m[$], ea[$], eb[$];
    logic [31:0] ra, rb;
    int base_a, base_b, idx, to, first_acc, last_acc, na, nb;
    bit acc, da, db;
    base_a = qa.size();
    base_b = qb.size();
    for (int i = len - 1; i >= 0; i--) m.push_back(msg[i]);
    ra = ra_k ? {28'd0, ra_tab} : crc_model(4, 32'h9, 32'h0, m);
    rb = rb_k ? {16'd0, rb_tab} : crc_model(16, 32'h1021, 32'hFFFF, m);
    if (PT) begin
      ea = m;
      eb = m;
    end
    for (int i = 3; i >= 0; i--) ea.push_back(ra[i]);
    for (int i = 15; i >= 0; i--) eb.push_back(rb[i]);
    stall_left = (stall_at >= 0) ? 3 : 0;
    stall_on   = 1'b0;
    if (!no_start) begin
      crc_start = 1'b1; crc_ready = 1'b0; data_valid = 1'b0; data_last = 1'b0;
      @(posedge clk); #1;
      crc_start = 1'b0;
      check("start_a", {dr_a, busy_a, val_a}, 32'd6);
      check("start_b", {dr_b, busy_b, val_b}, 32'd6);
    end
    idx = 0; to = 0; first_acc = 0; last_acc = 0;
    while (idx < len && to < 400) begin
      data       = m[idx];
      data_valid = ($urandom_range(99) >= gap_pct);
      data_last  = data_valid ? (idx == len - 1) : 1'($urandom_range(1));
      set_ready(stall_pct, stall_at, base_a, ea);
      #1 acc = data_valid && dr_a;
      if (acc && idx == 0) first_acc = cyc + 1;
      if (acc && idx == len - 1) last_acc = cyc + 1;
      @(posedge clk); #1;
      if (acc) idx++;
      to++;
    end
    check("data_accept_count", idx, len);
    data_valid = 1'b0; data_last = 1'b0;
    to = 0; da = 1'b0; db = 1'b0;
    while (to < 400) begin
      na = qa.size() - base_a;
      nb = qb.size() - base_b;
      if (abort_after >= 0 && na == abort_after) return;
      if (chain && val_a && na == ea.size() - 1) begin
        crc_start = 1'b1; crc_ready = 1'b1;
        @(posedge clk); #1;
        crc_start = 1'b0;
        check("chain_open_a", {dr_a, busy_a, val_a}, 32'd6);
        cmp_stream("chain_a", qa, la, base_a, ea);
        return;
      end
      if (!da && na >= ea.size()) begin
        check("busy_fall_a", busy_a, 32'd0);
        da = 1'b1;
      end
      if (!db && nb >= eb.size()) begin
        check("busy_fall_b", busy_b, 32'd0);
        db = 1'b1;
      end
      if (da && db) break;
      set_ready(stall_pct, stall_at, base_a, ea);
      @(posedge clk); #1;
      to++;
    end
    check("drain_done", {31'd0, da && db}, 32'd1);
    cmp_stream("stream_a", qa, la, base_a, ea);
    cmp_stream("stream_b", qb, lb, base_b, eb);
    if (stall_at >= 0) check("stall_cycles_left", stall_left, 32'd0);
    if (timing && qa.size() > base_a) begin
      check("first_latency", ca[base_a], PT ? first_acc : last_acc);
      check("contiguous", ca[qa.size()-1] - ca[base_a] + 1, ea.size());
    end
    crc_ready = 1'b1;
  endtask

  initial begin
    logic [71:0] rmsg;
    tab[0] = '{72'hB, 32'd4, 4'h5, 1'b1, 16'h0, 1'b0};
    tab[1] = '{72'h1, 32'd1, 4'h9, 1'b1, 16'h0, 1'b0};
    tab[2] = '{72'h0, 32'd4, 4'h0, 1'b1, 16'h0, 1'b0};
    tab[3] = '{72'h3, 32'd2, 4'h2, 1'b1, 16'h0, 1'b0};
    tab[4] = '{72'h10, 32'd5, 4'hE, 1'b1, 16'h0, 1'b0};
    tab[5] = '{72'h31_3233_3435_3637_3839, 32'd72, 4'h0, 1'b0, 16'h29B1, 1'b1};

    #12;
    check("reset_a", {dr_a, out_a, val_a, last_a, busy_a}, 32'd0);
    check("reset_b", {dr_b, out_b, val_b, last_b, busy_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    crc_ready = 1'b1;

    for (int i = 0; i < 6; i++)
      run_frame(tab[i].msg, tab[i].len, tab[i].ra, tab[i].ra_k, tab[i].rb, tab[i].rb_k,
                0, 0, -1, -1, 1'b0, 1'b0, 1'b1);

    // Three-cycle stall on the first CRC bit
    run_frame(72'hB, 4, 4'h5, 1'b1, 16'h0, 1'b0, 0, 0, PT ? 4 : 0, -1, 1'b0, 1'b0, 1'b0);

    // Abort after two CRC bits, then a fresh frame
    run_frame(72'hB, 4, 4'h5, 1'b1, 16'h0, 1'b0, 0, 0, -1, (PT ? 4 : 0) + 2, 1'b0, 1'b0, 1'b0);
    run_frame(72'hB, 4, 4'h5, 1'b1, 16'h0, 1'b0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1);

    // Back-to-back: crc_start together with the final CRC transfer
    run_frame(72'h6, 3, 4'h0, 1'b0, 16'h0, 1'b0, 0, 0, -1, -1, 1'b1, 1'b0, 1'b0);
    run_frame(72'hB, 4, 4'h5, 1'b1, 16'h0, 1'b0, 0, 0, -1, -1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a message
    crc_start = 1'b1;
    @(posedge clk); #1;
    crc_start = 1'b0; data = 1'b1; data_valid = 1'b1; data_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_a", {dr_a, out_a, val_a, last_a, busy_a}, 32'd0);
    check("midrst_b", {dr_b, out_b, val_b, last_b, busy_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; data_valid = 1'b1; data_last = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle_a", {dr_a, busy_a, val_a}, 32'd0);
      check("post_rst_idle_b", {dr_b, busy_b, val_b}, 32'd0);
    end
    data_valid = 1'b0; data_last = 1'b0;

    // Random frames with input gaps, stray data_last and output backpressure
    for (int f = 0; f < 30; f++) begin
      rmsg[31:0]  = $urandom;
      rmsg[63:32] = $urandom;
      rmsg[71:64] = 8'($urandom_range(255));
      run_frame(rmsg, $urandom_range(24, 1), 4'h0, 1'b0, 16'h0, 1'b0, 25, 30, -1, -1,
                1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
